hbc_bus_sync: RTL
=================

Name: hbc_bus_sync

Overview:
- Clock-domain front end for the 8-bit host bus interface (HBC).
- Synchronises the asynchronous host strobes (CSn, WRn, RDn), address and data into the clk domain.
- Converts each host access into single-cycle write commands and read request/acknowledge handshakes toward the register bank downstream.
- Drives the tri-state read data back to the host.

Parameters:
- SYNC_STAGES, 2, synchroniser depth for strobes, address and data (≥2).
- ADDR_W, 2, host address width.
- DATA_W, 8, host data width.
- RD_TIMEOUT, 15, cycles to wait for rd_ack before aborting a read.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- CSn  in  1  host chip select, active low, asynchronous
- WRn  in  1  host write strobe, active low, asynchronous
- RDn  in  1  host read strobe, active low, asynchronous
- address  in  ADDR_W  host address, asynchronous
- data_in  in  DATA_W  host data bus, pad input side
- data_out  out  DATA_W  read data to pad
- data_oe  out  1  pad output enable
- wr_stb  out  1  one-cycle write command
- wr_addr  out  ADDR_W  write address, valid with wr_stb
- wr_data  out  DATA_W  write data, valid with wr_stb
- rd_req  out  1  read request, held until rd_ack or timeout
- rd_addr  out  ADDR_W  read address, stable while rd_req is high
- rd_ack  in  1  register bank read acknowledge, one cycle
- rd_data  in  DATA_W  register bank read data, valid with rd_ack
- err  out  1  sticky error flag
- err_clr  in  1  clears err

Behaviour:
- Reset (async, rst_n low):
  - all synchroniser flops to idle level (strobes 1, address/data 0);
  - wr_stb=0, wr_addr=0, wr_data=0, rd_req=0, rd_addr=0, data_out=0, err=0;
  - FSM to IDLE.
  - Reset mid-access aborts the access with no wr_stb; the host must re-issue.
- Synchronisation: CSn, WRn, RDn, address and data_in each pass through SYNC_STAGES flops.
  - ws = sync(!WRn && !CSn); rs = sync(!RDn && !CSn).
  - One extra register holds ws_d, rs_d and the last sampled address/data for edge detection.
- data_oe = !RDn && !CSn, combinational from the pads so bus release is immediate. data_out is a register.
- FSM states: IDLE, WRITE, READ_REQ, READ_HOLD, WAIT_IDLE.
- IDLE:
  - ws rising -> WRITE.
  - rs rising -> READ_REQ: rd_req=1, rd_addr=synchronised address.
  - ws and rs both high -> protocol error: err=1, go to WAIT_IDLE.
- WRITE:
  - Each cycle with ws high, capture the synchronised address and data into a holding register.
  - On ws falling: wr_stb=1 for exactly one cycle with the held address/data (value from the last cycle ws was high), then IDLE.
  - Latency: host WRn rise to wr_stb is SYNC_STAGES+1 cycles.
  - rs rising during WRITE -> err=1, wr_stb suppressed, go to WAIT_IDLE.
- READ_REQ:
  - rd_ack -> data_out<=rd_data, rd_req=0, go to READ_HOLD.
  - No rd_ack within RD_TIMEOUT cycles of rd_req rising -> data_out<={DATA_W{1'b1}}, rd_req=0, err=1, go to READ_HOLD.
  - rs falls before ack (aborted read) -> rd_req held until ack or timeout; data is latched but unused; then IDLE via READ_HOLD.
- READ_HOLD: wait for rs low -> IDLE. data_out keeps its value until the next read completes.
- WAIT_IDLE: wait until ws and rs are both low -> IDLE.
- Host timing contract:
  - read strobe width ≥ SYNC_STAGES+RD_TIMEOUT+3 clk cycles;
  - write strobe width ≥ SYNC_STAGES+1 cycles;
  - gap between accesses ≥ SYNC_STAGES+2 cycles.
  - Shorter pulses may be missed silently.
- err: sticky, cleared by err_clr (one cycle). Set has priority over clear in the same cycle.
- rd_ack outside READ_REQ is ignored.

Optional Feature:
- Macro HBC_BUS_GLITCH_FILTER_EN.
- Defined: ws and rs are accepted only after the synchronised level has been stable for 3 consecutive cycles (3-bit shift register each); all edge latencies grow by 2 cycles.
- Undefined: the raw synchronised level is used directly; no added latency.

Decomposition:
- Package hbc_pkg:
  - FSM state enum hbc_state_t;
  - constants HBC_ADDR_W=2, HBC_DATA_W=8, HBC_RD_FAIL_DATA=8'hFF.
- Sub-module hbc_sync_cell: parameterised multi-bit SYNC_STAGES flop chain with async reset value parameter. Instantiated for strobes, address and data.

Test Plan:
- Write: CSn=0, WRn low 10 cycles, address=2, data=8'h5A -> exactly one wr_stb, wr_addr=2, wr_data=8'h5A, 3 cycles after WRn rises.
- Read: CSn=0, RDn low 30 cycles, address=1; bank returns rd_ack with 8'hC3 after 4 cycles -> rd_req high 4 cycles, rd_addr=1, data_out=8'hC3, data_oe follows RDn, err=0.
- Read timeout: rd_ack never asserted -> rd_req drops after 15 cycles, data_out=8'hFF, err=1; err_clr pulse -> err=0.
- Protocol error: WRn and RDn both low with CSn=0 -> err=1, no wr_stb, no rd_req; FSM returns to IDLE after both strobes release.
- Reset during write: rst_n low while WRn is low -> no wr_stb; after release, a full write of 8'h11 to address 3 produces a single correct wr_stb.
- CSn high: WRn/RDn toggled with CSn=1 -> no wr_stb, no rd_req, data_oe=0 throughout.

Source files
------------

// File: rtl/hbc_pkg.sv
// Shared types and constants for the HBC host bus front end.
package hbc_pkg;

    localparam int unsigned HBC_ADDR_W = 2;
    localparam int unsigned HBC_DATA_W = 8;
    localparam logic [HBC_DATA_W-1:0] HBC_RD_FAIL_DATA = 8'hFF;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StReadReq,
        StReadHold,
        StWaitIdle
    } hbc_state_t;

endpackage

// File: rtl/hbc_sync_cell.sv
// Multi-bit flop chain synchroniser with a configurable reset value.
module hbc_sync_cell #(
    parameter int unsigned STAGES = 2,
    parameter int unsigned WIDTH = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    // Shift the asynchronous input through STAGES flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                chain[i] <= RST_VAL;
            end
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/hbc_bus_sync.sv
// HBC host bus front end: synchronises host strobes, address and data into
// the clk domain and turns host accesses into single-cycle write commands
// and read request/acknowledge handshakes toward the register bank.
// Optional macro HBC_BUS_GLITCH_FILTER_EN: strobes are accepted only after
// three consecutive equal synchronised samples (+2 cycles edge latency).
module hbc_bus_sync
    import hbc_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ADDR_W      = HBC_ADDR_W,
    parameter int unsigned DATA_W      = HBC_DATA_W,
    parameter int unsigned RD_TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              CSn,
    input  logic              WRn,
    input  logic              RDn,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    output logic              wr_stb,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    input  logic [DATA_W-1:0] rd_data,
    output logic              err,
    input  logic              err_clr
);

    localparam int unsigned TMR_W = $clog2(RD_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(RD_TIMEOUT - 1);

    logic [2:0]        strb_s;
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] data_s;
    logic              ws_raw, rs_raw;
    logic              ws, rs;
    logic              ws_d, rs_d;
    hbc_state_t        state;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_data;
    logic [TMR_W-1:0]  tmr;

    // Strobes idle high so reset never looks like an access.
    hbc_sync_cell #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (3),
        .RST_VAL(3'b111)
    ) u_sync_strb (
        .clk  (clk),
        .rst_n(rst_n),
        .d    ({CSn, WRn, RDn}),
        .q    (strb_s)
    );

    hbc_sync_cell #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (ADDR_W),
        .RST_VAL('0)
    ) u_sync_addr (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (address),
        .q    (addr_s)
    );

    hbc_sync_cell #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (DATA_W),
        .RST_VAL('0)
    ) u_sync_data (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (data_in),
        .q    (data_s)
    );

    assign ws_raw = !strb_s[1] && !strb_s[2];
    assign rs_raw = !strb_s[0] && !strb_s[2];

    // Pad enable straight from the pins so the bus is released immediately.
    assign data_oe = !RDn && !CSn;

`ifdef HBC_BUS_GLITCH_FILTER_EN
    // Two history bits plus the current sample give three consecutive samples.
    logic [1:0] ws_hist, rs_hist;
    logic       ws_flt, rs_flt;

    // Accept a new level only when three samples agree, otherwise hold.
    always_comb begin
        ws = ws_flt;
        rs = rs_flt;
        if (ws_raw && (&ws_hist)) begin
            ws = 1'b1;
        end else if (!ws_raw && !(|ws_hist)) begin
            ws = 1'b0;
        end
        if (rs_raw && (&rs_hist)) begin
            rs = 1'b1;
        end else if (!rs_raw && !(|rs_hist)) begin
            rs = 1'b0;
        end
    end

    // Sample history and hold the last accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ws_hist <= 2'b00;
            rs_hist <= 2'b00;
            ws_flt  <= 1'b0;
            rs_flt  <= 1'b0;
        end else begin
            ws_hist <= {ws_hist[0], ws_raw};
            rs_hist <= {rs_hist[0], rs_raw};
            ws_flt  <= ws;
            rs_flt  <= rs;
        end
    end
`else
    assign ws = ws_raw;
    assign rs = rs_raw;
`endif

    // Delayed strobe levels for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ws_d <= 1'b0;
            rs_d <= 1'b0;
        end else begin
            ws_d <= ws;
            rs_d <= rs;
        end
    end

    // Access FSM with registered outputs; err set wins over err_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            wr_stb    <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            hold_addr <= '0;
            hold_data <= '0;
            rd_req    <= 1'b0;
            rd_addr   <= '0;
            data_out  <= '0;
            err       <= 1'b0;
            tmr       <= '0;
        end else begin
            wr_stb <= 1'b0;
            if (err_clr) begin
                err <= 1'b0;
            end
            case (state)
                StIdle: begin
                    if (ws && rs) begin
                        err   <= 1'b1;
                        state <= StWaitIdle;
                    end else if (ws && !ws_d) begin
                        hold_addr <= addr_s;
                        hold_data <= data_s;
                        state     <= StWrite;
                    end else if (rs && !rs_d) begin
                        rd_req  <= 1'b1;
                        rd_addr <= addr_s;
                        tmr     <= '0;
                        state   <= StReadReq;
                    end
                end
                StWrite: begin
                    if (rs && !rs_d) begin
                        err   <= 1'b1;
                        state <= StWaitIdle;
                    end else if (ws) begin
                        hold_addr <= addr_s;
                        hold_data <= data_s;
                    end else begin
                        wr_stb  <= 1'b1;
                        wr_addr <= hold_addr;
                        wr_data <= hold_data;
                        state   <= StIdle;
                    end
                end
                StReadReq: begin
                    // An aborted read still waits for ack or timeout.
                    if (rd_ack) begin
                        data_out <= rd_data;
                        rd_req   <= 1'b0;
                        state    <= StReadHold;
                    end else if (tmr == TMR_LAST) begin
                        data_out <= {DATA_W{1'b1}};
                        rd_req   <= 1'b0;
                        err      <= 1'b1;
                        state    <= StReadHold;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                StReadHold: begin
                    if (!rs) begin
                        state <= StIdle;
                    end
                end
                StWaitIdle: begin
                    if (!ws && !rs) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
